// File: rtl/reg_skid_flush.sv
// rtl/reg_skid_flush.sv - valid/ready pipeline stage with 2-entry skid buffer and flush
// in_ready depends only on registered state, rst and flush, so out_ready never reaches it combinationally.
module reg_skid_flush #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             acc;
  logic             drn;

  assign in_ready  = !rst && !flush && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (rst || flush) begin
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (acc && !drn) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (acc && drn) begin
            main_d  = in_data;
          end else if (drn) begin
            state_d = EMPTY;
            main_d  = RESET_VALUE;
          end
        end
        FULL: begin
          // Skid entry moves up so the oldest beat is always in main.
          if (drn) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = RESET_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RESET_VALUE;
          skid_d  = RESET_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    main_q  <= main_d;
    skid_q  <= skid_d;
  end

endmodule

// File: tb/tb_reg_skid_flush.sv
// tb/tb_reg_skid_flush.sv - directed and randomized checks of reg_skid_flush against a queue model
module tb_reg_skid_flush;

  localparam logic [31:0] A_RV = 32'hCAFE_0001;
  localparam logic [63:0] B_RV = 64'h0123_4567_89AB_CDEF;
  localparam logic [0:0]  C_RV = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  logic        c_in_ready, c_out_valid;
  logic [0:0]  c_in_data, c_out_data;
  logic [1:0]  c_occ;

  reg_skid_flush #(.WIDTH(32), .RESET_VALUE(A_RV)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  reg_skid_flush #(.WIDTH(64), .RESET_VALUE(B_RV)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  reg_skid_flush #(.WIDTH(1), .RESET_VALUE(C_RV)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(b_out_ready), .out_data(c_out_data),
    .occupancy(c_occ)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [31:0] d, input logic [1:0] o);
    check({tag, ".out_valid"}, 64'(a_out_valid), 64'(v));
    check({tag, ".out_data"},  64'(a_out_data),  64'(d));
    check({tag, ".occupancy"}, 64'(a_occ),       64'(o));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] mq[$];
  logic        m_acc, m_drn;
  int          vp, rp;

  initial begin
    rst = 1'b1; flush = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h77; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; c_in_data = '0;

    // Reset held two cycles with a beat offered
    #1;
    check("rst.in_ready", 64'(a_in_ready), 64'(0));
    repeat (2) begin
      step;
      chk_a("rst", 1'b0, A_RV, 2'd0);
      check("rst.in_ready_hold", 64'(a_in_ready), 64'(0));
    end
    rst = 1'b0;
    #1;
    check("rel.in_ready", 64'(a_in_ready), 64'(1));
    step;
    chk_a("rel.first", 1'b1, 32'h77, 2'd1);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    step;
    chk_a("rel.drain", 1'b0, A_RV, 2'd0);

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      a_in_valid = 1'b1; a_in_data = 32'(i);
      #1;
      check("stream.in_ready", 64'(a_in_ready), 64'(1));
      step;
      chk_a("stream", 1'b1, 32'(i), 2'd1);
    end
    a_in_valid = 1'b0;
    step;
    chk_a("stream.end", 1'b0, A_RV, 2'd0);

    // Stall and skid
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    step;
    chk_a("skid.a", 1'b1, 32'hA, 2'd1);
    a_in_data = 32'hB;
    check("skid.rdy_b", 64'(a_in_ready), 64'(1));
    step;
    chk_a("skid.b", 1'b1, 32'hA, 2'd2);
    a_in_data = 32'hC;
    check("skid.rdy_full", 64'(a_in_ready), 64'(0));
    step;
    chk_a("skid.full_hold", 1'b1, 32'hA, 2'd2);
    a_out_ready = 1'b1;
    step;
    chk_a("skid.out_b", 1'b1, 32'hB, 2'd1);
    step;
    chk_a("skid.out_c", 1'b1, 32'hC, 2'd1);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    repeat (2) begin
      step;
      chk_a("skid.c_held", 1'b1, 32'hC, 2'd1);
    end
    a_out_ready = 1'b1;
    step;
    chk_a("skid.empty", 1'b0, A_RV, 2'd0);

    // Flush while full with a beat offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h1;
    step;
    a_in_data = 32'h2;
    step;
    chk_a("flush.pre", 1'b1, 32'h1, 2'd2);
    flush = 1'b1; a_in_data = 32'hD;
    #1;
    check("flush.in_ready", 64'(a_in_ready), 64'(0));
    step;
    flush = 1'b0; a_in_valid = 1'b0;
    chk_a("flush.post", 1'b0, A_RV, 2'd0);
    a_out_ready = 1'b1;
    step;
    chk_a("flush.no_d", 1'b0, A_RV, 2'd0);

    // Simultaneous accept and drain in ONE
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h5;
    step;
    chk_a("accdrn.pre", 1'b1, 32'h5, 2'd1);
    a_out_ready = 1'b1; a_in_data = 32'h6;
    step;
    chk_a("accdrn.post", 1'b1, 32'h6, 2'd1);
    a_in_valid = 1'b0;
    step;
    chk_a("accdrn.empty", 1'b0, A_RV, 2'd0);

    // Randomized traffic on the 64-bit and 1-bit instances against a queue model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      vp = 30 + 30 * ((cyc / 500) % 3);
      rp = 20 + 35 * ((cyc / 1500) % 3);
      rst         = (cyc == 0) || ($urandom_range(511) == 0);
      flush       = ($urandom_range(63) == 0);
      b_in_valid  = ($urandom_range(99) < vp);
      b_out_ready = ($urandom_range(99) < rp);
      b_in_data   = {$urandom, $urandom};
      c_in_data   = b_in_data[0];
      #1;
      check("rnd.in_ready64", 64'(b_in_ready), 64'(!rst && !flush && mq.size() < 2));
      check("rnd.in_ready1",  64'(c_in_ready), 64'(!rst && !flush && mq.size() < 2));
      @(posedge clk);
      if (rst || flush) begin
        mq.delete();
      end else begin
        m_acc = b_in_valid && (mq.size() < 2);
        m_drn = b_out_ready && (mq.size() > 0);
        if (m_drn) void'(mq.pop_front());
        if (m_acc) mq.push_back(b_in_data);
      end
      #1;
      check("rnd.valid64", 64'(b_out_valid), 64'(mq.size() > 0));
      check("rnd.data64",  b_out_data, (mq.size() > 0) ? mq[0] : B_RV);
      check("rnd.occ64",   64'(b_occ), 64'(mq.size()));
      check("rnd.valid1",  64'(c_out_valid), 64'(mq.size() > 0));
      check("rnd.data1",   64'(c_out_data), 64'((mq.size() > 0) ? mq[0][0] : C_RV[0]));
      check("rnd.occ1",    64'(c_occ), 64'(mq.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
